// File: rtl/dest_reg_reader_if.sv
// Bus bundle for dest_reg_reader: command, register-file port and output stream.
// The slave modport is the reader itself; master is whatever surrounds it.
interface dest_reg_reader_if #(
    parameter int I_WIDTH = 4,
    parameter int D_WIDTH = 16
);
    logic               start;
    logic [I_WIDTH-1:0] base_idx;
    logic [I_WIDTH:0]   count;
    logic               busy;
    logic               done;

    logic [I_WIDTH-1:0] idx_out;
    logic               r_en_out;
    logic               w_en_out;
    logic [D_WIDTH-1:0] wr_data_out;
    logic [D_WIDTH-1:0] rd_data_in;

    logic [D_WIDTH-1:0] out_data;
    logic [I_WIDTH-1:0] out_index;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport slave (
        input  start, base_idx, count, rd_data_in, out_ready,
        output busy, done, idx_out, r_en_out, w_en_out, wr_data_out,
               out_data, out_index, out_valid, out_last
    );

    modport master (
        output start, base_idx, count, rd_data_in, out_ready,
        input  busy, done, idx_out, r_en_out, w_en_out, wr_data_out,
               out_data, out_index, out_valid, out_last
    );
endinterface

// File: rtl/dest_reg_reader.sv
// Drains a wrapping index range of the destination register file onto a valid/ready stream.
// Define DEST_READER_CLEAR_EN to zero each entry after its word is handed off.
module dest_reg_reader #(
    parameter int I_WIDTH = 4,
    parameter int D_WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    dest_reg_reader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
`ifdef DEST_READER_CLEAR_EN
        VALID,
        CLR
`else
        VALID
`endif
    } state_t;

    state_t             state;
    logic [I_WIDTH-1:0] cur_idx;
    logic [I_WIDTH:0]   remaining;

    logic               busy_r;
    logic               done_r;
    logic [I_WIDTH-1:0] idx_r;
    logic               r_en_r;
    logic               w_en_r;
    logic [D_WIDTH-1:0] data_r;
    logic [I_WIDTH-1:0] index_r;
    logic               valid_r;
    logic               last_r;

    logic               last_word;
    logic [I_WIDTH-1:0] next_idx;

    assign last_word = (remaining == (I_WIDTH + 1)'(1));
    assign next_idx  = cur_idx + 1'b1;

    // Every output is a register; done, r_en and w_en default low so they only pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_idx   <= '0;
            remaining <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            idx_r     <= '0;
            r_en_r    <= 1'b0;
            w_en_r    <= 1'b0;
            data_r    <= '0;
            index_r   <= '0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            r_en_r <= 1'b0;
            w_en_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.count == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            cur_idx   <= bus.base_idx;
                            idx_r     <= bus.base_idx;
                            remaining <= bus.count;
                            busy_r    <= 1'b1;
                            r_en_r    <= 1'b1;
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                // The register file only drives real data the cycle after a read.
                CAP: begin
                    data_r  <= bus.rd_data_in;
                    index_r <= cur_idx;
                    last_r  <= last_word;
                    valid_r <= 1'b1;
                    state   <= VALID;
                end
                VALID: begin
                    if (bus.out_ready) begin
                        valid_r <= 1'b0;
`ifdef DEST_READER_CLEAR_EN
                        idx_r  <= index_r;
                        w_en_r <= 1'b1;
                        state  <= CLR;
`else
                        remaining <= remaining - 1'b1;
                        if (last_word) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            cur_idx <= next_idx;
                            idx_r   <= next_idx;
                            r_en_r  <= 1'b1;
                            state   <= RD;
                        end
`endif
                    end
                end
`ifdef DEST_READER_CLEAR_EN
                CLR: begin
                    remaining <= remaining - 1'b1;
                    if (last_word) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cur_idx <= next_idx;
                        idx_r   <= next_idx;
                        r_en_r  <= 1'b1;
                        state   <= RD;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.idx_out     = idx_r;
    assign bus.r_en_out    = r_en_r;
    assign bus.w_en_out    = w_en_r;
    assign bus.wr_data_out = '0;
    assign bus.out_data    = data_r;
    assign bus.out_index   = index_r;
    assign bus.out_valid   = valid_r;
    assign bus.out_last    = last_r;

    // The register file port must never see a read and a write together.
    r_w_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(r_en_r && w_en_r));

    hold_while_stalled: assert property (@(posedge clk) disable iff (rst)
        (valid_r && !bus.out_ready) |=>
            (valid_r && $stable(data_r) && $stable(index_r) && $stable(last_r)));
endmodule

// File: tb/tb_dest_reg_reader.sv
// Table-driven bench for dest_reg_reader with a register-file model and a word scoreboard.
`timescale 1ns/1ps
module tb_dest_reg_reader;
    localparam int IW     = 4;
    localparam int DW     = 16;
    localparam int DEPTH  = 16;
    localparam int BUDGET = 200;
`ifdef DEST_READER_CLEAR_EN
    localparam int CPW   = 4;
    localparam bit CLEAR = 1'b1;
`else
    localparam int CPW   = 3;
    localparam bit CLEAR = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } item_t;

    typedef struct {
        logic [IW-1:0] base;
        logic [IW:0]   count;
        int            stall_word;
        int            stall_len;
        int            spur_cyc;
        int            exp_reads;
        int            exp_done;
        int            exp_first;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_en = 1'b0;
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] preload [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    item_t sb[$];
    vec_t  vecs[$];
    int tests = 0;
    int fails = 0;

    dest_reg_reader_if #(.I_WIDTH(IW), .D_WIDTH(DW)) bus ();

    dest_reg_reader #(.I_WIDTH(IW), .D_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file model: undriven reads return a poison word so early sampling shows up.
    always @(posedge clk) begin
        bus.rd_data_in <= bus.r_en_out ? mem[bus.idx_out] : 16'hDEAD;
        if (load_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= preload[i];
        end else if (bus.w_en_out) begin
            mem[bus.idx_out] <= bus.wr_data_out;
        end
    end

    task automatic reportFail(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) reportFail(name, act, exp);
        else tests++;
    endtask

    function automatic vec_t make_vec(int base, int count, int stall_word, int stall_len, int spur);
        vec_t v;
        v.base       = IW'(base);
        v.count      = (IW + 1)'(count);
        v.stall_word = stall_word;
        v.stall_len  = stall_len;
        v.spur_cyc   = spur;
        v.exp_reads  = count;
        v.exp_done   = (count == 0) ? 1 : count * CPW + stall_len + 1;
        v.exp_first  = (count == 0) ? 0 : 3;
        return v;
    endfunction

    task automatic reloadMem();
        for (int i = 0; i < DEPTH; i++) begin
            preload[i] = (i < 4) ? DW'((i + 1) * 17) : DW'(32'h1000 + i * 32'h0101);
            ref_mem[i] = preload[i];
        end
        load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic checkMem();
        for (int i = 0; i < DEPTH; i++)
            checkOutput($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));
    endtask

    task automatic checkResetValues();
        checkOutput("rst_busy",      32'(bus.busy),        0);
        checkOutput("rst_done",      32'(bus.done),        0);
        checkOutput("rst_idx_out",   32'(bus.idx_out),     0);
        checkOutput("rst_r_en",      32'(bus.r_en_out),    0);
        checkOutput("rst_w_en",      32'(bus.w_en_out),    0);
        checkOutput("rst_wr_data",   32'(bus.wr_data_out), 0);
        checkOutput("rst_out_data",  32'(bus.out_data),    0);
        checkOutput("rst_out_index", 32'(bus.out_index),   0);
        checkOutput("rst_out_valid", 32'(bus.out_valid),   0);
        checkOutput("rst_out_last",  32'(bus.out_last),    0);
    endtask

    // Queues the expected words, then pulses start so edge 0 samples it.
    task automatic applyStimulus(input logic [IW-1:0] base, input logic [IW:0] count);
        for (int i = 0; i < int'(count); i++) begin
            logic [IW-1:0] idx;
            idx = base + IW'(i);
            sb.push_back('{data: ref_mem[idx], idx: idx, last: (i == int'(count) - 1)});
        end
        bus.base_idx  = base;
        bus.count     = count;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic popAndCompare(inout int handshakes);
        item_t e;
        if (sb.size() == 0) begin
            reportFail("extra_word", 32'(bus.out_index), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            checkOutput("out_data",  32'(bus.out_data),  32'(e.data));
            checkOutput("out_index", 32'(bus.out_index), 32'(e.idx));
            checkOutput("out_last",  32'(bus.out_last),  32'(e.last));
            if (CLEAR) ref_mem[e.idx] = '0;
        end
        handshakes++;
    endtask

    task automatic runVector(input vec_t v);
        int reads = 0, wens = 0, first = 0, done_at = 0, handshakes = 0;
        int stall_left = v.stall_len;
        reloadMem();
        applyStimulus(v.base, v.count);
        for (int n = 1; n <= BUDGET; n++) begin
            if (n == v.spur_cyc) begin
                bus.start    = 1'b1;
                bus.base_idx = 4'd8;
                bus.count    = 5'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.r_en_out) reads++;
            if (bus.w_en_out) wens++;
            if (bus.out_valid && first == 0) first = n;
            bus.out_ready = 1'b1;
            if (bus.out_valid && handshakes == v.stall_word && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
                if (sb.size() > 0) begin
                    checkOutput("stall_data",  32'(bus.out_data),  32'(sb[0].data));
                    checkOutput("stall_index", 32'(bus.out_index), 32'(sb[0].idx));
                end
            end
            if (bus.out_valid && bus.out_ready) popAndCompare(handshakes);
            checkOutput("busy", 32'(bus.busy), 32'(v.count != 0 && n < v.exp_done));
            if (bus.done) begin
                done_at = n;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("done_cycle",  done_at,    v.exp_done);
        checkOutput("read_pulses", reads,      v.exp_reads);
        checkOutput("words",       handshakes, int'(v.count));
        checkOutput("first_valid", first,      v.exp_first);
        checkOutput("w_en_pulses", wens,       CLEAR ? int'(v.count) : 0);
        checkOutput("sb_empty",    sb.size(),  0);
        @(posedge clk); #1;
        checkOutput("done_pulse_width", 32'(bus.done), 0);
        checkMem();
    endtask

    // Resets while word 2 is being presented; no done may follow and a new run must work.
    task automatic resetMidSequence();
        int handshakes = 0, done_seen = 0, reads = 0;
        bit found = 1'b0;
        reloadMem();
        applyStimulus(4'd0, 5'd4);
        for (int n = 1; n <= BUDGET; n++) begin
            if (bus.out_valid && handshakes == 1) begin
                found = 1'b1;
                break;
            end
            if (bus.out_valid && bus.out_ready) popAndCompare(handshakes);
            @(posedge clk); #1;
        end
        if (!found) reportFail("reach_word2_timeout", 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkResetValues();
        sb.delete();
        for (int n = 0; n < 12; n++) begin
            if (bus.done) done_seen++;
            if (bus.r_en_out) reads++;
            @(posedge clk); #1;
        end
        checkOutput("no_done_after_reset", done_seen, 0);
        checkOutput("no_read_after_reset", reads,     0);
        checkMem();
        runVector(make_vec(3, 2, -1, 0, 0));
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_idx  = '0;
        bus.count     = '0;
        bus.out_ready = 1'b1;

        vecs.push_back(make_vec(0,  4,  -1, 0, 0));
        vecs.push_back(make_vec(2,  3,  1,  5, 0));
        vecs.push_back(make_vec(15, 3,  -1, 0, 0));
        vecs.push_back(make_vec(0,  0,  -1, 0, 0));
        vecs.push_back(make_vec(0,  16, -1, 0, 0));
        vecs.push_back(make_vec(15, 2,  -1, 0, 0));
        vecs.push_back(make_vec(4,  2,  -1, 0, 0));
        vecs.push_back(make_vec(0,  2,  -1, 0, 2));
        vecs.push_back(make_vec(9,  1,  0,  3, 0));

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues();
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) runVector(vecs[i]);
        resetMidSequence();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/dest_reg_reader.md
# dest_reg_reader

Sequential drain engine for the destination register file. On a start command it walks a contiguous, wrapping index range, issues one read per entry, captures the returned word and presents it on a valid/ready output stream toward the next DNN layer or the host. It sits between the destination register file's index, read-enable and data ports and any downstream consumer.

## Interface
- I_WIDTH, 4, index width; the register file holds 2**I_WIDTH entries
- D_WIDTH, 16, data word width
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle command pulse, sampled only in IDLE
- base_idx  input  I_WIDTH  first index to read, sampled with start
- count  input  I_WIDTH+1  number of entries to read, 0 to 2**I_WIDTH, sampled with start
- busy  output  1  high from the cycle after an accepted start until the done pulse
- done  output  1  one-cycle pulse when the sequence completes
- idx_out  output  I_WIDTH  index to the register file
- r_en_out  output  1  read enable to the register file
- w_en_out  output  1  write enable to the register file (clear feature only)
- wr_data_out  output  D_WIDTH  write data to the register file, always 0
- rd_data_in  input  D_WIDTH  read data from the register file, valid the cycle after r_en_out
- out_data  output  D_WIDTH  stream word
- out_index  output  I_WIDTH  index the word came from
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready from the consumer
- out_last  output  1  high with the final word of the sequence

## Operation
- States: IDLE, RD, CAP, VALID, CLR (CLR exists only with the clear feature).
- IDLE: on start with count==0, pulse done next cycle and stay in IDLE. On start with count>0, latch cur_idx=base_idx, remaining=count, go to RD.
- RD: idx_out=cur_idx, r_en_out=1 for exactly one cycle; go to CAP.
- CAP: register rd_data_in into out_data and cur_idx into out_index; out_last is set when remaining==1; go to VALID. rd_data_in is sampled only in CAP, since the register file drives high-impedance when not read.
- VALID: out_valid=1 and out_data, out_index and out_last are held stable until out_valid&&out_ready. On the handshake, go to CLR if the clear feature is compiled in, otherwise advance.
- Advance: decrement remaining; if it reaches 0, go to IDLE and pulse done; otherwise increment cur_idx modulo 2**I_WIDTH and go to RD.
- start outside IDLE is ignored, and base_idx/count are not resampled.
- idx_out holds cur_idx in every state. r_en_out and w_en_out are never high in the same cycle.

## Timing
- Reset values: busy=0, done=0, idx_out=0, r_en_out=0, w_en_out=0, wr_data_out=0, out_data=0, out_index=0, out_valid=0, out_last=0, state=IDLE.
- rst asserted mid-sequence takes effect at the next edge: state returns to IDLE, any pending word is dropped and no done pulse is issued.
- Start sampled at edge 0. RD occupies cycle 1, CAP cycle 2, and out_valid is first high in cycle 3.
- With out_ready held high, each word costs 3 cycles (RD, CAP, VALID), or 4 cycles with CLR.
- done is high in the cycle after the final handshake (or the final CLR), together with busy falling.
- Wrap-around: base_idx=2**I_WIDTH-1 with count=2 reads the last index, then index 0.
- count=2**I_WIDTH reads every entry exactly once.

## Configuration
- DEST_READER_CLEAR_EN
  - Defined: after each stream handshake the block spends one CLR cycle with idx_out=out_index, w_en_out=1 and wr_data_out=0, so it zeroes each drained entry ready for the next accumulation pass.
  - Undefined: the CLR state is absent, w_en_out is constant 0 and the register file contents are left unchanged.

## Test plan
- Reset, preload entries 0–3 with 0x0011/0x0022/0x0033/0x0044, start base=0 count=4, out_ready=1 -> four words in order with out_index 0..3, out_last only on 0x0044, done one cycle after the last handshake, first out_valid in cycle 3.
- Backpressure: hold out_ready=0 for 5 cycles while a word is presented -> out_data/out_index stay stable, no extra r_en_out pulses, and no word is lost or duplicated.
- Wrap-around: base=15 count=3 with I_WIDTH=4 -> indices 15, 0, 1.
- Edge cases: count=0 -> done after 1 cycle with no r_en_out; count=16 -> 16 words; a start pulse while busy -> ignored.
- Reset mid-sequence: assert rst while in VALID of word 2 -> all outputs return to reset values next cycle and no done pulse; a new start then runs cleanly.
- With DEST_READER_CLEAR_EN defined: after draining base=4 count=2, entries 4 and 5 read back 0 and all other entries are unchanged; without the macro, w_en_out is never 1.
